// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, mid-bit sampling, valid/ack
// holding register with frame-error pulse and sticky overrun flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_i,
  input  logic       ack_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n, ovr_n;
  logic          rx_m, rx_s;

  // Synchronizer resets to the idle-high level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      data_o      <= data_n;
      valid_o     <= valid_n;
      frame_err_o <= ferr_n;
      overrun_o   <= ovr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = data_o;
    valid_n   = valid_o;
    ferr_n    = 1'b0;
    ovr_n     = overrun_o;

    if (ack_i && valid_o) valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            cnt_n     = '0;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            // A completing byte takes priority over a same-cycle ack.
            data_n  = shreg;
            valid_n = 1'b1;
            if (valid_o && !ack_i) ovr_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

endmodule
